// File: rtl/alsaqr_axi4_mem_slave.sv
// AXI4 memory slave backed by a word-addressed SRAM array.
// Independent single-burst read and write engines with INCR/FIXED bursts, byte strobes and decode errors.
module alsaqr_axi4_mem_slave #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     s_axi_awid_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
    input  logic [7:0]              s_axi_awlen_i,
    input  logic [2:0]              s_axi_awsize_i,
    input  logic [1:0]              s_axi_awburst_i,
    input  logic                    s_axi_awlock_i,
    input  logic [3:0]              s_axi_awcache_i,
    input  logic [2:0]              s_axi_awprot_i,
    input  logic [3:0]              s_axi_awqos_i,
    input  logic [3:0]              s_axi_awregion_i,
    input  logic [USER_WIDTH-1:0]   s_axi_awuser_i,
    input  logic                    s_axi_awvalid_i,
    output logic                    s_axi_awready_o,
    input  logic [ID_WIDTH-1:0]     s_axi_wid_i,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
    input  logic                    s_axi_wlast_i,
    input  logic [USER_WIDTH-1:0]   s_axi_wuser_i,
    input  logic                    s_axi_wvalid_i,
    output logic                    s_axi_wready_o,
    output logic [ID_WIDTH-1:0]     s_axi_bid_o,
    output logic [1:0]              s_axi_bresp_o,
    output logic [USER_WIDTH-1:0]   s_axi_buser_o,
    output logic                    s_axi_bvalid_o,
    input  logic                    s_axi_bready_i,
    input  logic [ID_WIDTH-1:0]     s_axi_arid_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
    input  logic [7:0]              s_axi_arlen_i,
    input  logic [2:0]              s_axi_arsize_i,
    input  logic [1:0]              s_axi_arburst_i,
    input  logic                    s_axi_arlock_i,
    input  logic [3:0]              s_axi_arcache_i,
    input  logic [2:0]              s_axi_arprot_i,
    input  logic [3:0]              s_axi_arqos_i,
    input  logic [3:0]              s_axi_arregion_i,
    input  logic [USER_WIDTH-1:0]   s_axi_aruser_i,
    input  logic                    s_axi_arvalid_i,
    output logic                    s_axi_arready_o,
    output logic [ID_WIDTH-1:0]     s_axi_rid_o,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
    output logic [1:0]              s_axi_rresp_o,
    output logic                    s_axi_rlast_o,
    output logic [USER_WIDTH-1:0]   s_axi_ruser_o,
    output logic                    s_axi_rvalid_o,
    input  logic                    s_axi_rready_i
);

    localparam int unsigned STRB  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(STRB);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(MEM_WORDS * STRB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (off < WIN_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return off[OFF_W +: IDX_W];
    endfunction

    // WRAP is deliberately handled like INCR; only FIXED holds the address.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        if (burst == BURST_FIXED) begin
            return addr;
        end else begin
            return addr + (ADDR_WIDTH'(1) << size);
        end
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            aw_len_q, aw_len_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic [1:0]            w_resp_q, w_resp_d;
    logic                  mem_we_s;
    logic                  w_last_s;
    logic [IDX_W-1:0]      w_idx_s;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic                  rd_load_s;

    logic unused_s;
    assign unused_s = ^{s_axi_awlock_i, s_axi_awcache_i, s_axi_awprot_i, s_axi_awqos_i,
                        s_axi_awregion_i, s_axi_awuser_i, s_axi_wid_i, s_axi_wuser_i,
                        s_axi_arlock_i, s_axi_arcache_i, s_axi_arprot_i, s_axi_arqos_i,
                        s_axi_arregion_i, s_axi_aruser_i};

    // Write engine next-state: AW latch, beat write/error tracking, B response.
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_resp_d   = w_resp_q;
        mem_we_s   = 1'b0;
        w_last_s   = (w_cnt_q == aw_len_q);
        w_idx_s    = word_idx(aw_addr_q);
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid_i) begin
                    aw_id_d    = s_axi_awid_i;
                    aw_addr_d  = s_axi_awaddr_i;
                    aw_len_d   = s_axi_awlen_i;
                    aw_size_d  = s_axi_awsize_i;
                    aw_burst_d = s_axi_awburst_i;
                    w_cnt_d    = 8'd0;
                    w_resp_d   = RESP_OKAY;
                    w_state_d  = W_DATA;
                end else begin
                    w_state_d  = W_IDLE;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid_i) begin
                    mem_we_s  = in_window(aw_addr_q);
                    // DECERR outranks a wlast mismatch once flagged.
                    if (!in_window(aw_addr_q)) begin
                        w_resp_d = RESP_DECERR;
                    end else if ((s_axi_wlast_i != w_last_s) && (w_resp_q != RESP_DECERR)) begin
                        w_resp_d = RESP_SLVERR;
                    end else begin
                        w_resp_d = w_resp_q;
                    end
                    aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_burst_q);
                    w_cnt_d   = w_cnt_q + 8'd1;
                    if (w_last_s) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (s_axi_bready_i) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write engine state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= {ID_WIDTH{1'b0}};
            aw_addr_q  <= {ADDR_WIDTH{1'b0}};
            aw_len_q   <= 8'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'b00;
            w_cnt_q    <= 8'd0;
            w_resp_q   <= RESP_OKAY;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_resp_q   <= w_resp_d;
        end
    end

    // Array write with per-byte strobes; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB; b++) begin
                if (s_axi_wstrb_i[b]) begin
                    mem_q[w_idx_s][8*b +: 8] <= s_axi_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read engine next-state: AR latch and per-beat array fetch into the R register.
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        rlast_d    = rlast_q;
        rd_addr_s  = ar_addr_q;
        rd_load_s  = 1'b0;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid_i) begin
                    ar_id_d    = s_axi_arid_i;
                    ar_addr_d  = s_axi_araddr_i;
                    ar_len_d   = s_axi_arlen_i;
                    ar_size_d  = s_axi_arsize_i;
                    ar_burst_d = s_axi_arburst_i;
                    r_cnt_d    = 8'd0;
                    rd_addr_s  = s_axi_araddr_i;
                    rd_load_s  = 1'b1;
                    rlast_d    = (s_axi_arlen_i == 8'd0);
                    r_state_d  = R_DATA;
                end else begin
                    r_state_d  = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi_rready_i) begin
                    if (r_cnt_q == ar_len_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        rd_addr_s = next_addr(ar_addr_q, ar_size_q, ar_burst_q);
                        ar_addr_d = rd_addr_s;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        rd_load_s = 1'b1;
                        rlast_d   = (r_cnt_d == ar_len_q);
                        r_state_d = R_DATA;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_load_s) begin
            if (in_window(rd_addr_s)) begin
                rdata_d = mem_q[word_idx(rd_addr_s)];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = {DATA_WIDTH{1'b0}};
                rresp_d = RESP_DECERR;
            end
        end else begin
            rdata_d = rdata_q;
            rresp_d = rresp_q;
        end
    end

    // Read engine state registers; the fetch samples pre-write array contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= {ID_WIDTH{1'b0}};
            ar_addr_q  <= {ADDR_WIDTH{1'b0}};
            ar_len_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'b00;
            r_cnt_q    <= 8'd0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    assign s_axi_awready_o = (w_state_q == W_IDLE);
    assign s_axi_wready_o  = (w_state_q == W_DATA);
    assign s_axi_bvalid_o  = (w_state_q == W_RESP);
    assign s_axi_bid_o     = aw_id_q;
    assign s_axi_bresp_o   = w_resp_q;
    assign s_axi_buser_o   = {USER_WIDTH{1'b0}};
    assign s_axi_arready_o = (r_state_q == R_IDLE);
    assign s_axi_rvalid_o  = (r_state_q == R_DATA);
    assign s_axi_rid_o     = ar_id_q;
    assign s_axi_rdata_o   = rdata_q;
    assign s_axi_rresp_o   = rresp_q;
    assign s_axi_rlast_o   = rlast_q;
    assign s_axi_ruser_o   = {USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_alsaqr_axi4_mem_slave.sv
// Directed self-checking bench for alsaqr_axi4_mem_slave: inputs driven and outputs sampled on the falling edge.
module tb_alsaqr_axi4_mem_slave;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   awid, arid, wid, bid, rid;
    logic [63:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize, awprot, arprot;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awlock, arlock, awvalid, arvalid, awready, arready;
    logic [3:0]   awcache, arcache, awqos, arqos, awregion, arregion;
    logic [0:0]   awuser, aruser, wuser, buser, ruser;
    logic [511:0] wdata, rdata;
    logic [63:0]  wstrb;
    logic         wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

    int tests  = 0;
    int failed = 0;

    logic [511:0] wbeat   [0:7];
    logic [63:0]  wstrb_a [0:7];
    logic [511:0] rexp    [0:7];
    logic [1:0]   rrexp   [0:7];

    always #5 clk = ~clk;

    alsaqr_axi4_mem_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid_i(awid), .s_axi_awaddr_i(awaddr), .s_axi_awlen_i(awlen), .s_axi_awsize_i(awsize),
        .s_axi_awburst_i(awburst), .s_axi_awlock_i(awlock), .s_axi_awcache_i(awcache), .s_axi_awprot_i(awprot),
        .s_axi_awqos_i(awqos), .s_axi_awregion_i(awregion), .s_axi_awuser_i(awuser),
        .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
        .s_axi_wid_i(wid), .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wlast_i(wlast),
        .s_axi_wuser_i(wuser), .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
        .s_axi_bid_o(bid), .s_axi_bresp_o(bresp), .s_axi_buser_o(buser), .s_axi_bvalid_o(bvalid),
        .s_axi_bready_i(bready),
        .s_axi_arid_i(arid), .s_axi_araddr_i(araddr), .s_axi_arlen_i(arlen), .s_axi_arsize_i(arsize),
        .s_axi_arburst_i(arburst), .s_axi_arlock_i(arlock), .s_axi_arcache_i(arcache), .s_axi_arprot_i(arprot),
        .s_axi_arqos_i(arqos), .s_axi_arregion_i(arregion), .s_axi_aruser_i(aruser),
        .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
        .s_axi_rid_o(rid), .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rlast_o(rlast),
        .s_axi_ruser_o(ruser), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int wlast_beat, input logic [1:0] exp_resp,
                            input int bdelay);
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd6; awburst = burst; awvalid = 1'b1;
        chk("awready_idle", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
        chk("wready_after_aw", wready, 1'b1);
        chk("awready_busy", awready, 1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wbeat[i]; wstrb = wstrb_a[i]; wlast = (i == wlast_beat);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid", bvalid, 1'b1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp);
        chk("wready_resp", wready, 1'b0);
        for (int d = 0; d < bdelay; d++) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1'b1);
            chk("awready_hold", awready, 1'b0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 1'b0);
        chk("awready_back", awready, 1'b1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle);
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = 3'd6; arburst = burst; arvalid = 1'b1;
        chk("arready_idle", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("arready_busy", arready, 1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            if (toggle) begin
                rready = 1'b0;
                @(negedge clk);
                chk("stall_rvalid", rvalid, 1'b1);
                chk("stall_rdata", rdata, rexp[i]);
                chk("stall_rresp", rresp, rrexp[i]);
                chk("stall_rlast", rlast, (i == int'(len)));
            end
            rready = 1'b1;
            chk("rvalid", rvalid, 1'b1);
            chk("rid", rid, id);
            chk("rdata", rdata, rexp[i]);
            chk("rresp", rresp, rrexp[i]);
            chk("rlast", rlast, (i == int'(len)));
            @(negedge clk);
        end
        rready = 1'b0;
        chk("rvalid_drop", rvalid, 1'b0);
        chk("arready_back", arready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        awid = 4'd0; awaddr = 64'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'b01; awlock = 1'b0;
        awcache = 4'd0; awprot = 3'd0; awqos = 4'd0; awregion = 4'd0; awuser = 1'b0; awvalid = 1'b0;
        arid = 4'd0; araddr = 64'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'b01; arlock = 1'b0;
        arcache = 4'd0; arprot = 3'd0; arqos = 4'd0; arregion = 4'd0; aruser = 1'b0; arvalid = 1'b0;
        wid = 4'd0; wdata = 512'd0; wstrb = 64'd0; wlast = 1'b0; wuser = 1'b0; wvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wstrb_a[i] = {64{1'b1}};
            rrexp[i]   = 2'b00;
        end
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_awready", awready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_bid", bid, 4'd0);
        chk("rst_rid", rid, 4'd0);
        chk("rst_rdata", rdata, 512'd0);
        chk("rst_buser", buser, 1'b0);
        chk("rst_ruser", ruser, 1'b0);
        rst_n = 1'b1;

        // Single write then read
        wbeat[0] = {64{8'hA5}};
        do_write(4'd3, BASE, 8'd0, 2'b01, 0, 2'b00, 0);
        rexp[0] = {64{8'hA5}};
        do_read(4'd5, BASE, 8'd0, 2'b01, 1'b0);

        // Word 3 preset so the partial-strobe beat shows old bytes
        wbeat[0] = {512{1'b1}};
        do_write(4'd1, BASE + 64'hC0, 8'd0, 2'b01, 0, 2'b00, 0);

        // 4-beat INCR burst with strobe 0x0F on beat 2
        for (int i = 0; i < 4; i++) wbeat[i] = 512'(i + 1);
        wstrb_a[2] = 64'h0F;
        do_write(4'd7, BASE + 64'h40, 8'd3, 2'b01, 3, 2'b00, 0);
        wstrb_a[2] = {64{1'b1}};
        rexp[0] = 512'd1;
        rexp[1] = 512'd2;
        rexp[2] = {{480{1'b1}}, 32'h0000_0003};
        rexp[3] = 512'd4;
        do_read(4'd2, BASE + 64'h40, 8'd3, 2'b01, 1'b0);

        // Backpressure: R stalls every other cycle, B held 5 cycles
        do_read(4'd9, BASE + 64'h40, 8'd3, 2'b01, 1'b1);
        wbeat[0] = 512'hC3;
        do_write(4'd4, BASE + 64'h400, 8'd0, 2'b01, 0, 2'b00, 5);
        rexp[0] = 512'hC3;
        do_read(4'd4, BASE + 64'h400, 8'd0, 2'b01, 1'b0);

        // Decode error: burst runs off the window end, read below base
        wbeat[0] = 512'h11;
        wbeat[1] = 512'h22;
        do_write(4'd6, BASE + 64'h1_0000 - 64'h40, 8'd1, 2'b01, 1, 2'b11, 0);
        rexp[0] = 512'h11;  rrexp[0] = 2'b00;
        rexp[1] = 512'd0;   rrexp[1] = 2'b11;
        do_read(4'd6, BASE + 64'h1_0000 - 64'h40, 8'd1, 2'b01, 1'b0);
        rexp[0] = 512'd0;   rrexp[0] = 2'b11;
        rrexp[1] = 2'b00;
        do_read(4'd8, BASE - 64'h40, 8'd0, 2'b01, 1'b0);
        rrexp[0] = 2'b00;

        // FIXED burst with early wlast: one word, last data wins, SLVERR
        wbeat[0] = 512'hB0;
        wbeat[1] = 512'hB1;
        wbeat[2] = 512'hB2;
        do_write(4'd10, BASE + 64'h200, 8'd2, 2'b00, 0, 2'b10, 0);
        for (int i = 0; i < 3; i++) rexp[i] = 512'hB2;
        do_read(4'd11, BASE + 64'h200, 8'd2, 2'b00, 1'b0);

        // Reset during beat 2 of an 8-beat read
        @(negedge clk);
        arid = 4'd12; araddr = BASE + 64'h40; arlen = 8'd7; arsize = 3'd6; arburst = 2'b01; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        chk("mid_beat0", rdata, 512'd1);
        @(negedge clk);
        chk("mid_beat1", rdata, 512'd2);
        @(negedge clk);
        chk("mid_beat2_valid", rvalid, 1'b1);
        rst_n = 1'b0; rready = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_rlast", rlast, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_arready", arready, 1'b1);
        rexp[0] = 512'd1;
        rexp[1] = 512'd2;
        rexp[2] = {{480{1'b1}}, 32'h0000_0003};
        rexp[3] = 512'd4;
        do_read(4'd13, BASE + 64'h40, 8'd3, 2'b01, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
